// File: rtl/game_pkg.sv
// Shared types and constants for the memory-game controller: state encoding,
// level count and the fixed per-level symbol patterns.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHOW     = 3'd1,
        S_INPUT    = 3'd2,
        S_LVL_DONE = 3'd3,
        S_WIN      = 3'd4,
        S_LOSE     = 3'd5
    } state_t;

    localparam int NUM_LEVELS = 3;
    localparam int PATTERN_W  = 9;

    // Entry [n] is the pattern for level n; the MSB is shown first.
    localparam logic [NUM_LEVELS-1:0][PATTERN_W-1:0] LEVEL_PATTERNS = {
        9'b111000111,
        9'b110011001,
        9'b101010101
    };

endpackage

// File: rtl/game_ctrl_if.sv
// Player/display-side signal bundle of game_ctrl; the controller is the slave,
// the environment driving start/tick/buttons is the master.
interface game_ctrl_if;

    logic       start;
    logic       tick;
    logic       btn_valid;
    logic       btn_val;
    logic       show_valid;
    logic       show_bit;
    logic [1:0] level;
    logic [1:0] lives;
    logic [7:0] score;
    logic [3:0] pos;
    logic [2:0] state_o;
    logic       win;
    logic       game_over;

    modport master (
        output start, tick, btn_valid, btn_val,
        input  show_valid, show_bit, level, lives, score, pos, state_o, win, game_over
    );

    modport slave (
        input  start, tick, btn_valid, btn_val,
        output show_valid, show_bit, level, lives, score, pos, state_o, win, game_over
    );

endinterface

// File: rtl/game_ctrl_pattern_rom.sv
// Combinational level-to-pattern lookup; unused level codes return all zeros.
module pattern_rom
    import game_pkg::*;
(
    input  logic [1:0]           i_level,
    output logic [PATTERN_W-1:0] o_pattern
);

    assign o_pattern = (i_level < 2'(NUM_LEVELS)) ? LEVEL_PATTERNS[i_level] : '0;

endmodule

// File: rtl/game_ctrl.sv
// Memory-game sequencer: shows a level pattern on ticks, then checks player input.
// Optional per-symbol input timeout is enabled with the GAME_CTRL_TIMEOUT_EN macro.
//
// state    | meaning
// IDLE     | waiting for start after reset
// SHOW     | one pattern symbol displayed per tick
// INPUT    | comparing player entries against the pattern
// LVL_DONE | single-cycle level advance
// WIN/LOSE | terminal, start begins a new game
module game_ctrl
    import game_pkg::*;
#(
    parameter int SEQ_LEN       = 9,
    parameter int MAX_LIVES     = 3,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic        clk,
    input  logic        reset,
    game_ctrl_if.slave  bus
);

    if (SEQ_LEN < 1 || SEQ_LEN > PATTERN_W || TIMEOUT_TICKS < 1) begin : g_bad_params
        $error("game_ctrl: SEQ_LEN must be 1..9 and TIMEOUT_TICKS at least 1");
    end

    state_t                 r_state;
    state_t                 w_nxt_state;
    logic [1:0]             r_level;
    logic [1:0]             r_lives;
    logic [7:0]             r_score;
    logic [3:0]             r_pos;
    logic                   r_show_valid;
    logic                   r_show_bit;
    logic                   r_win;
    logic                   r_game_over;

    logic [1:0]             w_nxt_level;
    logic [1:0]             w_nxt_lives;
    logic [7:0]             w_nxt_score;
    logic [3:0]             w_nxt_pos;
    logic                   w_nxt_show_valid;
    logic                   w_nxt_show_bit;
    logic                   w_miss;
    logic                   w_timeout;
    logic [PATTERN_W-1:0]   w_pattern;
    logic [3:0]             w_sym_idx;
    logic                   w_exp_sym;
    logic                   w_last_pos;
    logic [7:0]             w_score_inc;

    pattern_rom u_pattern_rom (
        .i_level   (r_level),
        .o_pattern (w_pattern)
    );

    assign w_sym_idx   = 4'(SEQ_LEN - 1) - r_pos;
    assign w_exp_sym   = w_pattern[w_sym_idx];
    assign w_last_pos  = (r_pos == 4'(SEQ_LEN - 1));
    assign w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;

`ifdef GAME_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    // Down-counter of remaining idle ticks; expiry is the tick seen at zero.
    logic [TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_state == S_INPUT) && bus.tick && !bus.btn_valid && (r_to_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || (r_state != S_INPUT) || bus.btn_valid || w_timeout) begin
            r_to_cnt <= TO_W'(TIMEOUT_TICKS - 1);
        end else if (bus.tick) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_level      = r_level;
        w_nxt_lives      = r_lives;
        w_nxt_score      = r_score;
        w_nxt_pos        = r_pos;
        w_nxt_show_valid = 1'b0;
        w_nxt_show_bit   = 1'b0;
        w_miss           = 1'b0;

        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (bus.start) begin
                    w_nxt_level = 2'd0;
                    w_nxt_lives = 2'(MAX_LIVES);
                    w_nxt_score = 8'd0;
                    w_nxt_pos   = 4'd0;
                    w_nxt_state = S_SHOW;
                end
            end
            S_SHOW: begin
                if (bus.tick) begin
                    w_nxt_show_valid = 1'b1;
                    w_nxt_show_bit   = w_exp_sym;
                    if (w_last_pos) begin
                        w_nxt_pos   = 4'd0;
                        w_nxt_state = S_INPUT;
                    end else begin
                        w_nxt_pos = r_pos + 4'd1;
                    end
                end
            end
            S_INPUT: begin
                // A button wins over a coincident tick, so timeout only fires without one.
                if (bus.btn_valid) begin
                    if (bus.btn_val == w_exp_sym) begin
                        w_nxt_score = w_score_inc;
                        if (w_last_pos) begin
                            w_nxt_state = S_LVL_DONE;
                        end else begin
                            w_nxt_pos = r_pos + 4'd1;
                        end
                    end else begin
                        w_miss = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_miss = 1'b1;
                end

                if (w_miss) begin
                    if (r_lives <= 2'd1) begin
                        w_nxt_lives = 2'd0;
                        w_nxt_state = S_LOSE;
                    end else begin
                        w_nxt_lives = r_lives - 2'd1;
                    end
                end
            end
            S_LVL_DONE: begin
                if (r_level == 2'(NUM_LEVELS - 1)) begin
                    w_nxt_state = S_WIN;
                end else begin
                    w_nxt_level = r_level + 2'd1;
                    w_nxt_pos   = 4'd0;
                    w_nxt_state = S_SHOW;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level      <= 2'd0;
            r_lives      <= 2'd0;
            r_score      <= 8'd0;
            r_pos        <= 4'd0;
            r_show_valid <= 1'b0;
            r_show_bit   <= 1'b0;
            r_win        <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_level      <= w_nxt_level;
            r_lives      <= w_nxt_lives;
            r_score      <= w_nxt_score;
            r_pos        <= w_nxt_pos;
            r_show_valid <= w_nxt_show_valid;
            r_show_bit   <= w_nxt_show_bit;
            r_win        <= (w_nxt_state == S_WIN);
            r_game_over  <= (w_nxt_state == S_LOSE);
        end
    end

    assign bus.show_valid = r_show_valid;
    assign bus.show_bit   = r_show_bit;
    assign bus.level      = r_level;
    assign bus.lives      = r_lives;
    assign bus.score      = r_score;
    assign bus.pos        = r_pos;
    assign bus.state_o    = r_state;
    assign bus.win        = r_win;
    assign bus.game_over  = r_game_over;

endmodule
